// File: rtl/distributor_pkg.sv
// distributor_pkg: shared types for the sparse column distributor.
// Rev 1.0
`default_nettype none

package distributor_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_P  = 3'd1,
    S_LOAD_P   = 3'd2,
    S_FETCH_VZ = 3'd3,
    S_SEND     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int DEF_NUM_PU       = 4;
  localparam int DEF_D_WIDTH      = 16;
  localparam int DEF_W_ADDR_WIDTH = 10;
  localparam int PU_SEL_W         = $clog2(DEF_NUM_PU);

  // Push payload layout for the default configuration.
  typedef struct packed {
    logic [DEF_D_WIDTH-1:0]               weight;
    logic [DEF_D_WIDTH-1:0]               act;
    logic [DEF_W_ADDR_WIDTH-PU_SEL_W-1:0] row;
  } push_t;

endpackage

`default_nettype wire

// File: rtl/pu_router.sv
// pu_router: one-hot PU push decode, registered payload, per-PU full select.
// Rev 1.0
`default_nettype none

module pu_router #(
  parameter int NUM_PU  = 4,
  parameter int SEL_W   = 2,
  parameter int D_WIDTH = 16,
  parameter int ROW_W   = 8
) (
  input  logic               l_clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [D_WIDTH-1:0] weight_i,
  input  logic [D_WIDTH-1:0] act_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [NUM_PU-1:0]  pu_full_i,
  output logic               sel_full_o,
  output logic [NUM_PU-1:0]  pu_valid_o,
  output logic [D_WIDTH-1:0] pu_weight_o,
  output logic [D_WIDTH-1:0] pu_act_o,
  output logic [ROW_W-1:0]   pu_row_o
);

  logic [NUM_PU-1:0]  w_full_hit;
  logic [NUM_PU-1:0]  pu_valid_d;
  logic [NUM_PU-1:0]  pu_valid_q;
  logic [D_WIDTH-1:0] weight_q;
  logic [D_WIDTH-1:0] act_q;
  logic [ROW_W-1:0]   row_q;

  for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    assign w_full_hit[i] = (sel_i == IDX) & pu_full_i[i];
    assign pu_valid_d[i] = (sel_i == IDX) & push_i;
  end

  assign sel_full_o = |w_full_hit;

  always_ff @(posedge l_clk or negedge rst) begin
    if (!rst) begin
      pu_valid_q <= '0;
      weight_q   <= '0;
      act_q      <= '0;
      row_q      <= '0;
    end else begin
      pu_valid_q <= pu_valid_d;
      if (push_i) begin
        weight_q <= weight_i;
        act_q    <= act_i;
        row_q    <= row_i;
      end
    end
  end

  assign pu_valid_o  = pu_valid_q;
  assign pu_weight_o = weight_q;
  assign pu_act_o    = act_q;
  assign pu_row_o    = row_q;

endmodule

`default_nettype wire

// File: rtl/sparse_col_distributor.sv
// sparse_col_distributor: walks one compressed weight column and routes pushes to NUM_PU queues.
// Rev 1.0. Option DISTRIBUTOR_SKIP_ZERO_EN: a zero activation completes without reads or pushes.
`default_nettype none

module sparse_col_distributor
  import distributor_pkg::*;
#(
  parameter int NUM_PU       = 4,
  parameter int D_WIDTH      = 16,
  parameter int A_WIDTH      = 4,
  parameter int W_ADDR_WIDTH = 10,
  parameter int Z_WIDTH      = 4,
  parameter int SEL_W        = $clog2(NUM_PU)
) (
  input  logic                          l_clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [A_WIDTH-1:0]            col_i,
  input  logic [D_WIDTH-1:0]            act_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [A_WIDTH:0]              p_addr0_o,
  output logic [A_WIDTH:0]              p_addr1_o,
  input  logic [W_ADDR_WIDTH-1:0]       p_data0_i,
  input  logic [W_ADDR_WIDTH-1:0]       p_data1_i,
  output logic [W_ADDR_WIDTH-1:0]       vz_addr_o,
  input  logic [D_WIDTH-1:0]            v_data_i,
  input  logic [Z_WIDTH-1:0]            z_data_i,
  input  logic [NUM_PU-1:0]             pu_full_i,
  output logic [NUM_PU-1:0]             pu_valid_o,
  output logic [D_WIDTH-1:0]            pu_weight_o,
  output logic [D_WIDTH-1:0]            pu_act_o,
  output logic [W_ADDR_WIDTH-SEL_W-1:0] pu_row_o
);

  localparam logic [A_WIDTH:0]        PA_ONE = 1;
  localparam logic [W_ADDR_WIDTH-1:0] W_ONE  = 1;

  state_e                  state_q, state_d;
  logic [A_WIDTH:0]        p_addr0_q, p_addr1_q;
  logic [D_WIDTH-1:0]      act_q;
  logic [W_ADDR_WIDTH-1:0] iter_q, end_q, row_q;
  logic                    err_q;

  logic [W_ADDR_WIDTH-1:0] w_row;
  logic [W_ADDR_WIDTH-1:0] w_iter_inc;
  logic                    w_sel_full;
  logic                    w_push;

  // Row index is the previous row plus the zero-run plus one; wrap is modulo.
  assign w_row      = row_q + W_ADDR_WIDTH'(z_data_i) + W_ONE;
  assign w_iter_inc = iter_q + W_ONE;

  always_ff @(posedge l_clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef DISTRIBUTOR_SKIP_ZERO_EN
          if (act_i == '0) state_d = S_DONE;
          else             state_d = S_FETCH_P;
`else
          state_d = S_FETCH_P;
`endif
        end
      end
      S_FETCH_P:  state_d = S_LOAD_P;
      S_LOAD_P:   state_d = (p_data1_i <= p_data0_i) ? S_DONE : S_FETCH_VZ;
      S_FETCH_VZ: state_d = S_SEND;
      S_SEND: begin
        if (!w_sel_full) begin
          w_push  = 1'b1;
          state_d = (w_iter_inc == end_q) ? S_DONE : S_FETCH_VZ;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge l_clk or negedge rst) begin
    if (!rst) begin
      p_addr0_q <= '0;
      p_addr1_q <= '0;
      act_q     <= '0;
      iter_q    <= '0;
      end_q     <= '0;
      row_q     <= '1;
      err_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) err_q <= 1'b0;
      if (state_q == S_IDLE && state_d == S_FETCH_P) begin
        p_addr0_q <= {1'b0, col_i};
        p_addr1_q <= {1'b0, col_i} + PA_ONE;
        act_q     <= act_i;
      end
      if (state_q == S_LOAD_P) begin
        iter_q <= p_data0_i;
        end_q  <= p_data1_i;
        row_q  <= '1;
        err_q  <= (p_data1_i < p_data0_i);
      end
      if (w_push) begin
        iter_q <= w_iter_inc;
        row_q  <= w_row;
      end
    end
  end

  // iter_q doubles as the V/Z address so read data stays stable while stalled.
  assign vz_addr_o = iter_q;
  assign p_addr0_o = p_addr0_q;
  assign p_addr1_o = p_addr1_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = (state_q == S_DONE) & err_q;

  pu_router #(
    .NUM_PU  (NUM_PU),
    .SEL_W   (SEL_W),
    .D_WIDTH (D_WIDTH),
    .ROW_W   (W_ADDR_WIDTH-SEL_W)
  ) u_router (
    .l_clk       (l_clk),
    .rst         (rst),
    .push_i      (w_push),
    .sel_i       (w_row[SEL_W-1:0]),
    .weight_i    (v_data_i),
    .act_i       (act_q),
    .row_i       (w_row[W_ADDR_WIDTH-1:SEL_W]),
    .pu_full_i   (pu_full_i),
    .sel_full_o  (w_sel_full),
    .pu_valid_o  (pu_valid_o),
    .pu_weight_o (pu_weight_o),
    .pu_act_o    (pu_act_o),
    .pu_row_o    (pu_row_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_sparse_col_distributor.sv
// tb_sparse_col_distributor: directed scoreboard bench for sparse_col_distributor.
// Rev 1.0
`default_nettype none

module tb_sparse_col_distributor;

  localparam int NUM_PU = 4;
  localparam int D_W    = 16;
  localparam int A_W    = 4;
  localparam int W_W    = 10;
  localparam int Z_W    = 4;
  localparam int ROW_W  = W_W - 2;

  logic             l_clk = 1'b0;
  logic             rst;
  logic             start;
  logic [A_W-1:0]   col;
  logic [D_W-1:0]   act;
  logic             busy, done, err;
  logic [A_W:0]     p_addr0, p_addr1;
  logic [W_W-1:0]   p_data0, p_data1, vz_addr;
  logic [D_W-1:0]   v_data;
  logic [Z_W-1:0]   z_data;
  logic [NUM_PU-1:0] pu_full, pu_valid;
  logic [D_W-1:0]   pu_weight, pu_act;
  logic [ROW_W-1:0] pu_row;

  logic [W_W-1:0] pmem [0:31];
  logic [D_W-1:0] vmem [0:1023];
  logic [Z_W-1:0] zmem [0:1023];

  typedef struct {int pu; int row; int w; int a; int cyc;} push_exp_t;
  typedef struct {int cyc; int err;} done_exp_t;
  push_exp_t push_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  int cyc_now, idx;
  push_exp_t pe;
  done_exp_t de;

  sparse_col_distributor #(
    .NUM_PU(NUM_PU), .D_WIDTH(D_W), .A_WIDTH(A_W), .W_ADDR_WIDTH(W_W), .Z_WIDTH(Z_W)
  ) dut (
    .l_clk(l_clk), .rst(rst), .start_i(start), .col_i(col), .act_i(act),
    .busy_o(busy), .done_o(done), .err_o(err),
    .p_addr0_o(p_addr0), .p_addr1_o(p_addr1), .p_data0_i(p_data0), .p_data1_i(p_data1),
    .vz_addr_o(vz_addr), .v_data_i(v_data), .z_data_i(z_data),
    .pu_full_i(pu_full), .pu_valid_o(pu_valid),
    .pu_weight_o(pu_weight), .pu_act_o(pu_act), .pu_row_o(pu_row)
  );

  always #5 l_clk = ~l_clk;
  always @(posedge l_clk) cyc_cnt <= cyc_cnt + 1;

  // One-cycle synchronous memories.
  always @(posedge l_clk) begin
    p_data0 <= pmem[p_addr0];
    p_data1 <= pmem[p_addr1];
    v_data  <= vmem[vz_addr];
    z_data  <= zmem[vz_addr];
  end

  // Monitor: cycle numbers are relative to the start-accepting edge (cycle 1 follows it).
  always @(negedge l_clk) begin
    if (rst) begin
      cyc_now = cyc_cnt - t0 + 1;
      if (pu_valid != '0) begin
        checks++;
        idx = -1;
        for (int i = 0; i < NUM_PU; i++) if (pu_valid[i]) idx = i;
        if ($countones(pu_valid) != 1 || push_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: pu_valid=%b queued=%0d cycle=%0d", pu_valid, push_q.size(), cyc_now);
        end else begin
          pe = push_q.pop_front();
          if (idx != pe.pu || int'(pu_row) != pe.row || int'(pu_weight) != pe.w ||
              int'(pu_act) != pe.a || cyc_now != pe.cyc) begin
            errors++;
            $display("FAIL push: got pu=%0d row=%0d w=%0d a=%0d cyc=%0d, expected pu=%0d row=%0d w=%0d a=%0d cyc=%0d",
                     idx, pu_row, pu_weight, pu_act, cyc_now, pe.pu, pe.row, pe.w, pe.a, pe.cyc);
          end
        end
      end
      if (done || err) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=%0b err=%0b cycle=%0d", done, err, cyc_now);
        end else begin
          de = done_q.pop_front();
          if (!done || int'(err) != de.err || cyc_now != de.cyc) begin
            errors++;
            $display("FAIL done: got done=%0b err=%0b cyc=%0d, expected done=1 err=%0d cyc=%0d",
                     done, err, cyc_now, de.err, de.cyc);
          end
        end
      end
    end
  end

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic exp_push(int pu, int row, int w, int a, int cyc);
    push_q.push_back('{pu, row, w, a, cyc});
  endtask

  task automatic exp_done(int cyc, int e);
    done_q.push_back('{cyc, e});
  endtask

  task automatic load_scn1();
    pmem[3] = 10'd5; pmem[4] = 10'd8;
    vmem[5] = 16'd10; vmem[6] = 16'd20; vmem[7] = 16'd30;
    zmem[5] = 4'd0;   zmem[6] = 4'd2;   zmem[7] = 4'd1;
  endtask

  task automatic start_col(int c, int a);
    @(negedge l_clk);
    start = 1'b1; col = A_W'(c); act = D_W'(a);
    @(posedge l_clk);
    #1;
    start = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge l_clk);
      #2;
      if (!busy && push_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_complete"}, int'(ok), 1);
  endtask

  initial begin
    start = 1'b0; col = '0; act = '0; pu_full = '0;
    for (int i = 0; i < 32; i++) pmem[i] = '0;
    for (int i = 0; i < 1024; i++) begin vmem[i] = '0; zmem[i] = '0; end

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_ctrl", int'({busy, done, err, pu_valid}), 0);
    chk("reset_addr", int'({p_addr0, p_addr1, vz_addr}), 0);
    chk("reset_payload", int'({pu_weight, pu_act}) | int'(pu_row), 0);
    repeat (2) @(negedge l_clk);
    rst = 1'b1;

    // Basic three-entry column.
    load_scn1();
    exp_push(0, 0, 10, 7, 5); exp_push(3, 0, 20, 7, 7); exp_push(1, 1, 30, 7, 9);
    exp_done(9, 0);
    start_col(3, 7);
    @(negedge l_clk);
    chk("p_addr0_c1", int'(p_addr0), 3);
    chk("p_addr1_c1", int'(p_addr1), 4);
    wait_idle("basic");

    // Empty column.
    pmem[2] = 10'd6; pmem[3] = 10'd6;
    exp_done(3, 0);
    start_col(2, 7);
    wait_idle("empty");

    // Reversed pointers.
    pmem[5] = 10'd9; pmem[6] = 10'd4;
    exp_done(3, 1);
    start_col(5, 7);
    wait_idle("reversed");

    // PU3 full for cycles 6..10 delays the second push.
    load_scn1();
    exp_push(0, 0, 10, 7, 5); exp_push(3, 0, 20, 7, 12); exp_push(1, 1, 30, 7, 14);
    exp_done(14, 0);
    start_col(3, 7);
    repeat (5) @(posedge l_clk);
    #1 pu_full = 4'b1000;
    repeat (5) @(posedge l_clk);
    #1 pu_full = 4'b0000;
    wait_idle("stall");

    // Reset during the second SEND abandons the column.
    exp_push(0, 0, 10, 7, 5);
    start_col(3, 7);
    repeat (5) @(posedge l_clk);
    #2;
    chk("busy_before_reset", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", int'({busy, done, err, pu_valid}), 0);
    chk("midreset_addr", int'({p_addr0, p_addr1, vz_addr}), 0);
    chk("midreset_payload", int'({pu_weight, pu_act}) | int'(pu_row), 0);
    repeat (2) @(negedge l_clk);
    rst = 1'b1;
    chk("midreset_flush", push_q.size() + done_q.size(), 0);

    exp_push(0, 0, 10, 7, 5); exp_push(3, 0, 20, 7, 7); exp_push(1, 1, 30, 7, 9);
    exp_done(9, 0);
    start_col(3, 7);
    wait_idle("after_reset");

    // Top column: col+1 must not wrap.
    pmem[15] = '0; pmem[16] = '0;
    exp_done(3, 0);
    start_col(15, 7);
    @(negedge l_clk);
    chk("p_addr0_top", int'(p_addr0), 15);
    chk("p_addr1_top", int'(p_addr1), 16);
    wait_idle("top_col");

    // Zero activation.
    load_scn1();
`ifdef DISTRIBUTOR_SKIP_ZERO_EN
    exp_done(1, 0);
    start_col(3, 0);
    @(negedge l_clk);
    chk("zero_act_no_read", int'(p_addr0), 15);
`else
    exp_push(0, 0, 10, 0, 5); exp_push(3, 0, 20, 0, 7); exp_push(1, 1, 30, 0, 9);
    exp_done(9, 0);
    start_col(3, 0);
    @(negedge l_clk);
    chk("zero_act_read", int'(p_addr0), 3);
`endif
    wait_idle("zero_act");

    repeat (3) @(negedge l_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
